lstm_seq_ctrl: RTL and testbench

LSTM_SEQ_CTRL -- requirements
Module: lstm_seq_ctrl

---
 rtl/lstm_seq_ctrl.sv | 119 +++++++++++
 tb/tb_lstm_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: sequences timesteps through an external combinational LSTM cell
module lstm_seq_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int SETTLE     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [7:0]                   seq_len,
    input  logic                         abort,
    input  logic                         x_valid,
    input  logic signed [DATA_WIDTH-1:0] x_data,
    output logic                         x_ready,
    output logic [DATA_WIDTH-1:0]        cell_x,
    output logic [DATA_WIDTH-1:0]        cell_c_in,
    output logic [DATA_WIDTH-1:0]        cell_h_in,
    input  logic [DATA_WIDTH-1:0]        cell_c_out,
    input  logic [DATA_WIDTH-1:0]        cell_h_out,
    output logic                         h_valid,
    output logic [DATA_WIDTH-1:0]        h_data,
    input  logic                         h_ready,
    output logic [DATA_WIDTH-1:0]        c_final,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   step
);
    typedef enum logic [2:0] {IDLE, WAIT_X, EVAL, OUT, DONE} state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   x_reg, c_reg, h_reg;
    logic [7:0]              len;
    logic [3:0]              cnt;

    assign cell_x    = x_reg;
    assign cell_c_in = c_reg;
    assign cell_h_in = h_reg;
    assign c_final   = c_reg;

    // Sequencer: abort outranks every handshake; status outputs are registered alongside the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            x_reg   <= '0;
            c_reg   <= '0;
            h_reg   <= '0;
            h_data  <= '0;
            step    <= '0;
            len     <= '0;
            cnt     <= '0;
            x_ready <= 1'b0;
            h_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (abort) begin
            state   <= IDLE;
            x_ready <= 1'b0;
            h_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && seq_len != 8'd0) begin
                        c_reg   <= '0;
                        h_reg   <= '0;
                        step    <= '0;
                        len     <= seq_len;
                        state   <= WAIT_X;
                        x_ready <= 1'b1;
                        busy    <= 1'b1;
                    end else if (start) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                WAIT_X: begin
                    if (x_valid) begin
                        x_reg   <= x_data;
                        cnt     <= SETTLE_M1;
                        state   <= EVAL;
                        x_ready <= 1'b0;
                    end
                end
                EVAL: begin
                    if (cnt == 4'd0) begin
                        c_reg   <= cell_c_out;
                        h_reg   <= cell_h_out;
                        h_data  <= cell_h_out;
                        h_valid <= 1'b1;
                        state   <= OUT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                OUT: begin
                    if (h_ready) begin
                        h_valid <= 1'b0;
                        step    <= step + 8'd1;
                        if (step + 8'd1 == len) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state   <= WAIT_X;
                            x_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb_lstm_seq_ctrl: scoreboard bench for lstm_seq_ctrl with a stub LSTM cell
module tb_lstm_seq_ctrl;
    localparam int DW = 16;
    localparam int SETTLE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    seq_len = '0;
    logic          abort = 1'b0;
    logic          x_valid = 1'b0;
    logic signed [DW-1:0] x_data = '0;
    logic          x_ready;
    logic [DW-1:0] cell_x, cell_c_in, cell_h_in, cell_c_out, cell_h_out;
    logic          h_valid;
    logic [DW-1:0] h_data;
    logic          h_ready = 1'b1;
    logic [DW-1:0] c_final;
    logic          busy, done;
    logic [7:0]    step;

    typedef struct {
        logic [DW-1:0] h;
        logic [DW-1:0] c;
        logic [7:0]    st;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   hs_edge = 0;
    logic hv_prev = 1'b0;

    assign cell_c_out = cell_x + cell_c_in;
    assign cell_h_out = cell_h_in + 16'd1;

    lstm_seq_ctrl #(.DATA_WIDTH(DW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .abort(abort),
        .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
        .cell_x(cell_x), .cell_c_in(cell_c_in), .cell_h_in(cell_h_in),
        .cell_c_out(cell_c_out), .cell_h_out(cell_h_out),
        .h_valid(h_valid), .h_data(h_data), .h_ready(h_ready),
        .c_final(c_final), .busy(busy), .done(done), .step(step)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // Monitor: pops the scoreboard on every h handshake, counts done pulses, checks settle latency
    always @(negedge clk) begin
        if (rst) begin
            if (done) done_cnt++;
            if (x_valid && x_ready && !abort) hs_edge = cyc + 1;
            if (h_valid && !hv_prev) chk("h_latency", cyc - hs_edge, SETTLE);
            if (h_valid && h_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_h", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_h_data", h_data, e.h);
                    chk("sb_c_final", c_final, e.c);
                    chk("sb_step", step, e.st);
                end
            end
        end
        hv_prev = h_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [7:0] l);
        start = 1'b1;
        seq_len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send_x(input logic [DW-1:0] d);
        bit ok = 0;
        x_valid = 1'b1;
        x_data = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (x_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("x_ready_timeout", 0, 1);
        tick();
        x_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
        tick();
    endtask

    initial begin
        int d0;
        bit bad;
        logic [DW-1:0] hd;
        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_h_valid", h_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_step", step, 0);
        chk("rst_c_final", c_final, 0);
        chk("rst_h_data", h_data, 0);
        chk("rst_cell_x", cell_x, 0);
        tick();
        rst = 1'b1;
        tick();

        // three-step sequence, h_ready tied high
        d0 = done_cnt;
        start_seq(3);
        exp_q.push_back('{16'd1, 16'd1, 8'd0});
        exp_q.push_back('{16'd2, 16'd3, 8'd1});
        exp_q.push_back('{16'd3, 16'd6, 8'd2});
        send_x(1);
        send_x(2);
        send_x(3);
        wait_done();
        chk("seq3_c_final", c_final, 6);
        chk("seq3_step", step, 3);
        chk("seq3_h_data", h_data, 3);
        chk("seq3_done_cnt", done_cnt - d0, 1);
        chk("seq3_busy", busy, 0);

        // zero-length start
        d0 = done_cnt;
        bad = 0;
        start_seq(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy || x_ready) bad = 1;
        end
        tick();
        chk("len0_busy_xready", bad, 0);
        chk("len0_done_cnt", done_cnt - d0, 1);
        chk("len0_c_kept", c_final, 6);

        // back-pressure on the h stream
        h_ready = 1'b0;
        start_seq(1);
        exp_q.push_back('{16'd1, 16'd4, 8'd0});
        send_x(4);
        bad = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (h_valid) begin
                bad = 0;
                break;
            end
        end
        chk("bp_h_valid_seen", bad, 0);
        hd = h_data;
        chk("bp_h_data", hd, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", h_valid, 1);
            chk("bp_hold_data", h_data, hd);
            chk("bp_x_ready", x_ready, 0);
            chk("bp_step", step, 0);
        end
        tick();
        h_ready = 1'b1;
        wait_done();
        chk("bp_c_final", c_final, 4);
        chk("bp_step_end", step, 1);

        // abort coincident with an x handshake
        d0 = done_cnt;
        start_seq(2);
        exp_q.push_back('{16'd1, 16'd7, 8'd0});
        send_x(7);
        bad = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (x_ready) begin
                bad = 0;
                break;
            end
        end
        chk("ab_x_ready_seen", bad, 0);
        x_valid = 1'b1;
        x_data = 16'd9;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        x_valid = 1'b0;
        @(negedge clk);
        chk("ab_busy", busy, 0);
        chk("ab_x_ready", x_ready, 0);
        chk("ab_x_reg", cell_x, 7);
        chk("ab_h_valid", h_valid, 0);
        chk("ab_step", step, 1);
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("ab_no_done", done_cnt - d0, 0);
        chk("ab_c_kept", c_final, 7);
        tick();

        // reset mid-EVAL, then a fresh one-step sequence
        start_seq(2);
        send_x(3);
        rst = 1'b0;
        #1;
        chk("mr_x_ready", x_ready, 0);
        chk("mr_h_valid", h_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_step", step, 0);
        chk("mr_h_data", h_data, 0);
        chk("mr_c_final", c_final, 0);
        chk("mr_cell_x", cell_x, 0);
        chk("mr_cell_h_in", cell_h_in, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("mr_idle_busy", busy, 0);
        start_seq(1);
        exp_q.push_back('{16'd1, 16'd5, 8'd0});
        send_x(5);
        wait_done();
        chk("mr_c_final_end", c_final, 5);
        chk("mr_h_data_end", h_data, 1);

        // start while busy is ignored
        d0 = done_cnt;
        start_seq(2);
        exp_q.push_back('{16'd1, 16'd2, 8'd0});
        send_x(2);
        start_seq(5);
        exp_q.push_back('{16'd2, 16'd5, 8'd1});
        send_x(3);
        wait_done();
        chk("sb2_step", step, 2);
        chk("sb2_c_final", c_final, 5);
        chk("sb2_done_cnt", done_cnt - d0, 1);
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("sb2_idle_busy", busy, 0);

        chk("sb_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
